// File: rtl/hdb3_pkg.sv
// Shared HDB3 symbol definitions used by the V/B insertion stage and the
// downstream polarity stage.
package hdb3_pkg;

  // Plugged symbol carried between the insertion and polarity stages.
  typedef logic [1:0] code_t;

  localparam code_t CODE_ZERO = 2'b00;
  localparam code_t CODE_MARK = 2'b01;
  localparam code_t CODE_B    = 2'b10;
  localparam code_t CODE_V    = 2'b11;

  // HDB3 substitutes runs of four zeros; the delay line must hold a full run
  // so the first zero can still be rewritten to B when the fourth arrives.
  localparam int RUN_LEN = 4;
  localparam int DEPTH   = RUN_LEN;

  // Plain (unsubstituted) symbol for a binary input bit.
  function automatic code_t code_of_bit(input logic b);
    return b ? CODE_MARK : CODE_ZERO;
  endfunction

endpackage

// File: rtl/hdb3_delay_line.sv
// Four-entry symbol delay line. Entry 0 is newest, entry DEPTH-1 oldest.
// On shift, entry 0 takes d0_i and the entry moving into the oldest slot may
// be overridden (used to retro-fit the B pulse of a B00V substitution).
module hdb3_delay_line
  import hdb3_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  shift_en_i,
  input  code_t d0_i,
  input  logic  d3_ovr_i,
  input  code_t d3_code_i,
  output code_t d3_o
);

  code_t [DEPTH-1:0] d_q;

  // Newest entry loads the incoming (possibly V-substituted) symbol.
  always_ff @(posedge clk) begin
    if (rst)             d_q[0] <= CODE_ZERO;
    else if (shift_en_i) d_q[0] <= d0_i;
  end

  genvar k;
  generate
    for (k = 1; k < DEPTH; k++) begin : g_ent
      if (k == DEPTH-1) begin : g_last
        // Oldest entry: shifted value unless a B pulse is being planted.
        always_ff @(posedge clk) begin
          if (rst)             d_q[k] <= CODE_ZERO;
          else if (shift_en_i) d_q[k] <= d3_ovr_i ? d3_code_i : d_q[k-1];
        end
      end else begin : g_mid
        // Middle entries simply shift toward the oldest slot.
        always_ff @(posedge clk) begin
          if (rst)             d_q[k] <= CODE_ZERO;
          else if (shift_en_i) d_q[k] <= d_q[k-1];
        end
      end
    end
  endgenerate

  assign d3_o = d_q[DEPTH-1];

endmodule

// File: rtl/hdb3_vb_insert.sv
// HDB3 V/B insertion stage. Converts an NRZ bit stream into plugged symbols
// (zero / mark / B / V) with a fixed four-accept latency. Every run of four
// zeros becomes 000V when an odd number of pulses has been sent since the
// last V, otherwise B00V, so that consecutive V pulses alternate polarity
// once the polarity stage applies AMI rules.
module hdb3_vb_insert
  import hdb3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       out_valid,
  output logic [1:0] out_code,
  output logic       sub_pulse
);

  localparam logic [1:0] ZC_LAST = 2'(RUN_LEN - 1);
  localparam logic [2:0] F_FULL  = 3'(DEPTH);

  // Zero-run counter, pulse parity since last V, and fill level.
  logic [1:0] zc_q, zc_d;
  logic       p_q,  p_d;
  logic [2:0] f_q,  f_d;

  logic       sub;
  code_t      d0_code;
  logic       d3_ovr;
  code_t      d3;

  code_t      out_code_q;
  logic       out_valid_q;
  logic       sub_pulse_q;

  // Substitution fires on the fourth consecutive accepted zero.
  assign sub     = in_valid & ~in_bit & (zc_q == ZC_LAST);
  assign d0_code = sub ? CODE_V : code_of_bit(in_bit);
  // Even parity needs a B in place of the run's first zero to keep V
  // polarity alternating.
  assign d3_ovr  = sub & ~p_q;

  hdb3_delay_line u_dl (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (in_valid),
    .d0_i       (d0_code),
    .d3_ovr_i   (d3_ovr),
    .d3_code_i  (CODE_B),
    .d3_o       (d3)
  );

  // Next-state for run counter, parity and fill level on an accept.
  always_comb begin
    zc_d = zc_q;
    p_d  = p_q;
    f_d  = f_q;
    if (in_valid) begin
      if (in_bit) begin
        zc_d = '0;
        p_d  = ~p_q;
      end else if (sub) begin
        // V clears parity; a planted B is absorbed by the same clear.
        zc_d = '0;
        p_d  = 1'b0;
      end else begin
        zc_d = zc_q + 2'd1;
      end
      if (f_q != F_FULL) f_d = f_q + 3'd1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      zc_q <= '0;
      p_q  <= 1'b0;
      f_q  <= '0;
    end else begin
      zc_q <= zc_d;
      p_q  <= p_d;
      f_q  <= f_d;
    end
  end

  // Registered outputs: oldest symbol leaves on each accept, valid only
  // once the line has been filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_code_q  <= CODE_ZERO;
      out_valid_q <= 1'b0;
      sub_pulse_q <= 1'b0;
    end else begin
      if (in_valid) out_code_q <= d3;
      out_valid_q <= in_valid & (f_q == F_FULL);
      sub_pulse_q <= sub;
    end
  end

  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;
  assign sub_pulse = sub_pulse_q;

endmodule

// File: tb/tb_hdb3_vb_insert.sv
// Self-checking bench for hdb3_vb_insert: a queue-based HDB3 reference model
// feeds a scoreboard, plus directed sequences and stream-level properties.
module tb_hdb3_vb_insert;
  import hdb3_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_valid;
  logic [1:0] out_code;
  logic       sub_pulse;

  always #5 clk = ~clk;

  hdb3_vb_insert dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_code  (out_code),
    .sub_pulse (sub_pulse)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [1:0] m_q[$];
  logic [1:0] exp_out_q[$];
  int         m_zc = 0;
  int         m_f  = 0;
  bit         m_p  = 0;
  bit         exp_ov = 0;
  bit         exp_sub = 0;
  bit         was_rst = 1;

  // Observation state.
  logic [1:0] seen_q[$];
  logic [1:0] prev_code = 2'b00;
  int         sub_cnt = 0;
  bit         prop_en = 0;
  int         zrun = 0;
  int         npulse = 0;
  bit         seen_v = 0;

  // Model: every accepted bit is encoded into a symbol list; four zeros turn
  // into V with the run's first zero rewritten to B when parity is even.
  always @(posedge clk) begin
    bit ov_n, sub_n;
    ov_n = 0; sub_n = 0;
    if (rst) begin
      m_q.delete(); m_zc = 0; m_p = 0; m_f = 0;
    end else if (in_valid) begin
      if (m_f == 4) begin
        ov_n = 1;
        exp_out_q.push_back(m_q.pop_front());
      end else m_f++;
      if (in_bit) begin
        m_q.push_back(CODE_MARK); m_p = ~m_p; m_zc = 0;
      end else if (m_zc == 3) begin
        m_q.push_back(CODE_V);
        if (!m_p) m_q[m_q.size()-4] = CODE_B;
        m_p = 0; m_zc = 0; sub_n = 1;
      end else begin
        m_q.push_back(CODE_ZERO); m_zc++;
      end
    end
    exp_ov  = ov_n;
    exp_sub = sub_n;
    was_rst = rst;
  end

  // Monitor: compare registered outputs mid-cycle.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("sub_pulse", 32'(sub_pulse), 32'(exp_sub));
    if (exp_ov) begin
      if (exp_out_q.size() == 0) chk("sb_empty", 32'(0), 32'(1));
      else chk("out_code", 32'(out_code), 32'(exp_out_q.pop_front()));
    end
    if (out_valid) begin
      seen_q.push_back(out_code);
      if (prop_en) begin
        if (out_code == CODE_ZERO) begin
          zrun++;
          chk("zrun_lt4", 32'(zrun < 4), 32'(1));
        end else zrun = 0;
        if (out_code == CODE_V) begin
          if (seen_v) chk("v_sep_odd", 32'(npulse % 2), 32'(1));
          seen_v = 1; npulse = 0;
        end else if (out_code == CODE_MARK || out_code == CODE_B) npulse++;
      end
    end else if (!was_rst) begin
      chk("hold", 32'(out_code), 32'(prev_code));
    end
    prev_code = out_code;
    if (sub_pulse) sub_cnt++;
  end

  task automatic send(input logic b, input bit gap);
    in_valid = 1'b1; in_bit = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (gap) begin
      in_bit = ~b;
      @(posedge clk); #1;
    end
  endtask

  // Reset with input asserted, which must be ignored.
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
  endtask

  // Feed n bits msb-first from v.
  task automatic feed(input logic [15:0] v, input int n, input bit gap);
    for (int i = 0; i < n; i++) send(v[n-1-i], gap);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic start();
    seen_q.delete(); sub_cnt = 0;
    do_reset();
  endtask

  task automatic check_seq(input string tag, input logic [31:0] ev, input int n);
    chk({tag, "_len"}, 32'(seen_q.size()), 32'(n));
    for (int i = 0; i < n && i < seen_q.size(); i++)
      chk(tag, 32'(seen_q[i]), 32'(ev[2*(n-1-i) +: 2]));
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_code",  32'(out_code),  32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_sub",   32'(sub_pulse), 32'(0));
    #1;

    // 1,0000 + pad: 000V with odd parity.
    start();
    feed(16'b1_0000_1111, 9, 0);
    settle();
    check_seq("seq_000v", 32'b01_00_00_00_11, 5);
    chk("sub_000v", 32'(sub_cnt), 32'(1));

    // 1,1,0000 + pad: B00V with even parity.
    start();
    feed(16'b11_0000_1111, 10, 0);
    settle();
    check_seq("seq_b00v", 32'b01_01_10_00_00_11, 6);
    chk("sub_b00v", 32'(sub_cnt), 32'(1));

    // Eight zeros: two independent B00V substitutions.
    start();
    feed(16'b0000_0000_1111, 12, 0);
    settle();
    check_seq("seq_8z", 32'b10_00_00_11_10_00_00_11, 8);
    chk("sub_8z", 32'(sub_cnt), 32'(2));

    // Same as first case with idle gaps between accepts.
    start();
    feed(16'b1_0000_1111, 9, 1);
    settle();
    check_seq("seq_gap", 32'b01_00_00_00_11, 5);
    chk("sub_gap", 32'(sub_cnt), 32'(1));

    // Mid-run reset discards the partial zero run.
    start();
    feed(16'b000, 3, 0);
    do_reset();
    seen_q.delete();
    feed(16'b0_1111_1111, 9, 0);
    settle();
    check_seq("seq_mrst", 32'b00_01_01_01_01, 5);
    chk("sub_mrst", 32'(sub_cnt), 32'(0));

    // Random zero-biased stream with random idle gaps.
    start();
    prop_en = 1; zrun = 0; npulse = 0; seen_v = 0;
    for (int i = 0; i < 10000; i++)
      send(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    settle();
    prop_en = 0;
    chk("rand_count", 32'(seen_q.size()), 32'(10000 - 4));
    chk("rand_subs_seen", 32'(sub_cnt > 0), 32'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
